// File: rtl/gfx_mem_arbiter.sv
// Memory-port arbiter: round-robin reads, store priority with starvation relief, in-order read return.
// Latency: request path and response routing are combinational (zero cycles).
// Backpressure: mem_req_ready low locks the current winner; reads are blocked while the tag FIFO is full.
module gfx_mem_arbiter #(
  parameter int NUM_RD       = 3,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD-1:0]    rd_req_valid,
  input  logic [NUM_RD*32-1:0] rd_req_addr,
  input  logic [NUM_RD*5-1:0]  rd_req_tag,
  output logic [NUM_RD-1:0]    rd_req_ready,
  output logic [NUM_RD-1:0]    rd_resp_valid,
  output logic [31:0]          rd_resp_data,
  output logic [4:0]           rd_resp_tag,
  input  logic                 st_valid,
  input  logic [31:0]          st_addr,
  input  logic [31:0]          st_wdata,
  input  logic [3:0]           st_wstrb,
  output logic                 st_ready,
  output logic                 mem_req_valid,
  output logic                 mem_req_we,
  output logic [31:0]          mem_req_addr,
  output logic [31:0]          mem_req_wdata,
  output logic [3:0]           mem_req_wstrb,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [31:0]          mem_resp_data,
  output logic                 err_resp
);

  localparam int ID_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int ENT_W = ID_W + 5;
  localparam logic [ID_W:0] NUM_RD_W = (ID_W + 1)'(NUM_RD);

  // Outstanding-read FIFO: each entry is {requester id, tag}
  logic [ENT_W-1:0] fifo_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic             lock_q, lock_d, lock_st_q, lock_st_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic             err_q, err_d;

  logic              fifo_full, fifo_empty, any_rd;
  logic [NUM_RD-1:0] rd_elig, rd_rot;
  logic              rr_found;
  logic [ID_W:0]     rr_sum;
  logic [ID_W-1:0]   rr_id, sel_id, head_id;
  logic              sel_st, accept, push, pop;
  logic [ENT_W-1:0]  head;

  // Eligibility uses registered occupancy, so a same-cycle pop never frees a slot early
  always_comb begin
    fifo_full  = (count_q == CNT_W'(MAX_OUT));
    fifo_empty = (count_q == '0);
    rd_elig    = rd_req_valid & {NUM_RD{~fifo_full}};
    any_rd     = |rd_elig;
  end

  // Round-robin search: rotate so rr_ptr sits at bit 0, take the lowest set bit, map back
  always_comb begin
    rd_rot   = (rd_elig >> rr_ptr_q) | (rd_elig << (NUM_RD_W - {1'b0, rr_ptr_q}));
    rr_found = 1'b0;
    rr_sum   = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rr_found && rd_rot[j]) begin
        rr_found = 1'b1;
        rr_sum   = {1'b0, rr_ptr_q} + (ID_W + 1)'(j);
      end
    end
    if (rr_sum >= NUM_RD_W) rr_sum = rr_sum - NUM_RD_W;
    rr_id = rr_sum[ID_W-1:0];
  end

  // Winner selection: a locked winner holds the port; otherwise store priority unless reads are starved
  always_comb begin
    if (lock_q) begin
      sel_st        = lock_st_q;
      sel_id        = lock_id_q;
      mem_req_valid = lock_st_q ? st_valid : rd_elig[lock_id_q];
    end else begin
      sel_st        = st_valid & (~any_rd | (starve_cnt_q < SC_W'(STARVE_LIMIT)));
      sel_id        = rr_id;
      mem_req_valid = st_valid | any_rd;
    end
    accept = mem_req_valid & mem_req_ready;
    push   = accept & ~sel_st;
    pop    = mem_resp_valid & ~fifo_empty;
  end

  // Downstream request mux and per-source accept strobes
  always_comb begin
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    rd_req_ready  = '0;
    st_ready      = 1'b0;
    if (mem_req_valid) begin
      mem_req_we = sel_st;
      if (sel_st) begin
        mem_req_addr  = st_addr;
        mem_req_wdata = st_wdata;
        mem_req_wstrb = st_wstrb;
      end else begin
        mem_req_addr = rd_req_addr[sel_id*32 +: 32];
      end
    end
    if (accept) begin
      if (sel_st) st_ready = 1'b1;
      else        rd_req_ready = NUM_RD'(1) << sel_id;
    end
  end

  // Response routing from the FIFO head; responses with nothing outstanding are dropped
  always_comb begin
    head          = fifo_q[rd_ptr_q];
    head_id       = head[ENT_W-1:5];
    rd_resp_valid = pop ? (NUM_RD'(1) << head_id) : '0;
    rd_resp_data  = pop ? mem_resp_data : '0;
    rd_resp_tag   = pop ? head[4:0] : '0;
    err_resp      = err_q;
  end

  // Next-state for lock, fairness state, FIFO bookkeeping and the sticky error
  always_comb begin
    lock_d       = lock_q;
    lock_st_d    = lock_st_q;
    lock_id_d    = lock_id_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q | (mem_resp_valid & fifo_empty);

    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_req_valid) begin
      lock_d    = 1'b1;
      lock_st_d = sel_st;
      lock_id_d = sel_id;
    end

    if (push) begin
      rr_ptr_d     = ({1'b0, sel_id} == NUM_RD_W - 1'b1) ? '0 : sel_id + 1'b1;
      starve_cnt_d = '0;
    end else if (accept) begin
      if (!any_rd)                                    starve_cnt_d = '0;
      else if (starve_cnt_q != SC_W'(STARVE_LIMIT))   starve_cnt_d = starve_cnt_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_st_q    <= 1'b0;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_st_q    <= lock_st_d;
      lock_id_q    <= lock_id_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
    end
  end

  // FIFO storage: entries are only read when counted valid, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {sel_id, rd_req_tag[sel_id*5 +: 5]};
  end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Scoreboard bench for gfx_mem_arbiter: directed vectors push expected grants/responses,
// a negedge monitor pops and compares whenever the DUT accepts a request or returns a response.
module tb_gfx_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_req_valid;
  logic [95:0] rd_req_addr;
  logic [14:0] rd_req_tag;
  logic [2:0]  rd_req_ready;
  logic [2:0]  rd_resp_valid;
  logic [31:0] rd_resp_data;
  logic [4:0]  rd_resp_tag;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_ready;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        err_resp;

  gfx_mem_arbiter #(.NUM_RD(3), .MAX_OUT(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
    .rd_req_ready(rd_req_ready), .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .rd_resp_tag(rd_resp_tag), .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_wstrb(st_wstrb), .st_ready(st_ready), .mem_req_valid(mem_req_valid),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  rdy;
  } gnt_t;

  typedef struct packed {
    logic [2:0]  rv;
    logic [31:0] data;
    logic [4:0]  tag;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t mon_g;
  rsp_t mon_r;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_gnt(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] rdy);
    gnt_t g;
    g.we = we; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb; g.rdy = rdy;
    gq.push_back(g);
  endtask

  task automatic exp_rsp(input logic [2:0] rv, input logic [31:0] data, input logic [4:0] tag);
    rsp_t r;
    r.rv = rv; r.data = data; r.tag = tag;
    rq.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req_valid   = '0;
    st_valid       = 1'b0;
    st_addr        = '0;
    st_wdata       = '0;
    st_wstrb       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compare every accepted request and every response against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF);
        end else begin
          mon_g = gq.pop_front();
          chk("gnt_we", 64'(mem_req_we), 64'(mon_g.we));
          chk("gnt_addr", 64'(mem_req_addr), 64'(mon_g.addr));
          chk("gnt_wdata_wstrb", {28'd0, mem_req_wstrb, mem_req_wdata}, {28'd0, mon_g.wstrb, mon_g.wdata});
          chk("gnt_ready", 64'({st_ready, rd_req_ready}), 64'({mon_g.we, mon_g.rdy}));
        end
      end else begin
        chk("ready_idle", 64'({st_ready, rd_req_ready}), 64'd0);
      end
      if (|rd_resp_valid) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 64'(rd_resp_valid), 64'd0);
        end else begin
          mon_r = rq.pop_front();
          chk("rsp_valid", 64'(rd_resp_valid), 64'(mon_r.rv));
          chk("rsp_data", 64'(rd_resp_data), 64'(mon_r.data));
          chk("rsp_tag", 64'(rd_resp_tag), 64'(mon_r.tag));
        end
      end
    end
  end

  initial begin
    rd_req_addr = {32'h0000_1200, 32'h0000_1100, 32'h0000_1000};
    rd_req_tag  = {5'd18, 5'd17, 5'd16};
    idle();
    rst = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_readies", 64'({st_ready, rd_req_ready}), 64'd0);
    chk("rst_resp", 64'(rd_resp_valid), 64'd0);
    chk("rst_err", 64'(err_resp), 64'd0);
    tick();
    rst = 1'b0;

    // All three readers every cycle: grants 0,1,2,0,1,2; responses one cycle behind
    for (int k = 0; k < 7; k++) begin
      rd_req_valid   = (k < 6) ? 3'b111 : 3'b000;
      mem_req_ready  = 1'b1;
      mem_resp_valid = (k > 0);
      mem_resp_data  = 32'h0000_D000 + 32'(k);
      if (k < 6) exp_gnt(1'b0, 32'h1000 + 32'h100 * 32'(k % 3), 32'd0, 4'd0, 3'(1 << (k % 3)));
      if (k > 0) exp_rsp(3'(1 << ((k - 1) % 3)), 32'h0000_D000 + 32'(k), 5'(16 + (k - 1) % 3));
      tick();
    end

    // Starvation relief: 8 stores while read 0 waits, then read 0, then stores again
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rd_req_valid  = 3'b001;
      st_valid      = 1'b1;
      st_addr       = 32'h2000 + 32'd4 * 32'((k < 8) ? k : 8);
      st_wdata      = 32'((k < 8) ? k : 8);
      st_wstrb      = 4'hF;
      mem_req_ready = 1'b1;
      if (k < 8)       exp_gnt(1'b1, 32'h2000 + 32'd4 * 32'(k), 32'(k), 4'hF, 3'b000);
      else if (k == 8) exp_gnt(1'b0, 32'h1000, 32'd0, 4'd0, 3'b001);
      else             exp_gnt(1'b1, 32'h2020, 32'd8, 4'hF, 3'b000);
      tick();
    end
    idle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hAAAA_0000;
    exp_rsp(3'b001, 32'hAAAA_0000, 5'd16);
    tick();

    // Lock: read 1 held under backpressure, store raised at cycle 2 must wait
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rd_req_valid  = 3'b010;
      st_valid      = (k >= 2);
      st_addr       = 32'h3000;
      st_wdata      = 32'h55;
      st_wstrb      = 4'h3;
      mem_req_ready = 1'b0;
      @(negedge clk);
      if (k >= 2) begin
        chk("lock_we", 64'(mem_req_we), 64'd0);
        chk("lock_addr", 64'(mem_req_addr), 64'h1100);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    exp_gnt(1'b0, 32'h1100, 32'd0, 4'd0, 3'b010);
    tick();
    rd_req_valid = 3'b000;
    exp_gnt(1'b1, 32'h3000, 32'h55, 4'h3, 3'b000);
    tick();
    idle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    exp_rsp(3'b010, 32'h1234_5678, 5'd17);
    tick();

    // Tag FIFO full: reads blocked, stores still flow, a pop re-enables reads next cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rd_req_valid  = 3'b001;
      mem_req_ready = 1'b1;
      exp_gnt(1'b0, 32'h1000, 32'd0, 4'd0, 3'b001);
      tick();
    end
    @(negedge clk);
    chk("full_req_valid", 64'(mem_req_valid), 64'd0);
    chk("full_rd_ready", 64'(rd_req_ready), 64'd0);
    tick();
    st_valid = 1'b1;
    st_addr  = 32'h5000;
    st_wdata = 32'h77;
    st_wstrb = 4'h1;
    exp_gnt(1'b1, 32'h5000, 32'h77, 4'h1, 3'b000);
    tick();
    st_valid       = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h4001;
    exp_rsp(3'b001, 32'h4001, 5'd16);
    @(negedge clk);
    chk("full_pop_same_cycle", 64'(mem_req_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    exp_gnt(1'b0, 32'h1000, 32'd0, 4'd0, 3'b001);
    tick();
    rd_req_valid = 3'b000;
    for (int k = 2; k < 6; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h4000 + 32'(k);
      exp_rsp(3'b001, 32'h4000 + 32'(k), 5'd16);
      tick();
    end
    idle();

    // Response routing: reads from port 2 then port 0, answered in order
    do_reset();
    mem_req_ready = 1'b1;
    rd_req_valid  = 3'b100;
    exp_gnt(1'b0, 32'h1200, 32'd0, 4'd0, 3'b100);
    tick();
    rd_req_valid = 3'b001;
    exp_gnt(1'b0, 32'h1000, 32'd0, 4'd0, 3'b001);
    tick();
    rd_req_valid   = 3'b000;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_BABE;
    exp_rsp(3'b100, 32'hCAFE_BABE, 5'd18);
    tick();
    mem_resp_data = 32'h1122_3344;
    exp_rsp(3'b001, 32'h1122_3344, 5'd16);
    tick();
    idle();

    // Orphan response: dropped, sticky error until reset
    do_reset();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("orphan_no_resp", 64'(rd_resp_valid), 64'd0);
    chk("orphan_err_before", 64'(err_resp), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("orphan_err_set", 64'(err_resp), 64'd1);
    tick();
    tick();
    @(negedge clk);
    chk("orphan_err_sticky", 64'(err_resp), 64'd1);
    do_reset();
    @(negedge clk);
    chk("orphan_err_cleared", 64'(err_resp), 64'd0);
    tick();

    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
